// File: rtl/ysyx_23060072_lsu_stage.sv
// Load/store unit stage. It sits between ex_stage and wb_stage.
// It computes the effective address and runs one SRAM-style req/gnt/rvalid
// transaction per load or store. The pipeline is stalled while an access is
// in flight. The write-back bundle it hands to wb_stage is registered.
module ysyx_23060072_lsu_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_flag_i,
    input  logic [1:0]        LSU_type_i,
    input  logic              store_flag_i,
    input  logic              load_flag_i,
    input  logic              LSU_signed_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [31:0]       operand_a_i,
    input  logic [31:0]       operand_b_i,
    input  logic [31:0]       operand_imm_i,
    input  logic [31:0]       wb_data_ex_i,
    output logic              lsu_hold_flag_o,
    output logic              misaligned_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              wb_flag_o,
    output logic [4:0]        wb_addr_o,
    output logic [31:0]       wb_data_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [31:0]       ea_s;
    logic [31:0]       addr_word_s;
    logic              mem_op_s;
    logic              misaligned_s;
    logic              start_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [3:0]        mem_wstrb_r;
    logic [1:0]        off_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [4:0]        wb_addr_lat_r;
    logic              wb_flag_lat_r;
    logic              misaligned_r;
    logic              wb_flag_r;
    logic [4:0]        wb_addr_r;
    logic [31:0]       wb_data_r;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] fmt_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data across all lanes so that any strobe selects it.
    function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Extract the addressed lane from read data and extend it to 32 bits.
    function automatic logic [31:0] fmt_rdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic sgn, input logic [31:0] data);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = data[{off, 3'b000} +: 8];
        lane_h = data[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return {{24{sgn & lane_b[7]}}, lane_b};
            2'b01:   return {{16{sgn & lane_h[15]}}, lane_h};
            default: return data;
        endcase
    endfunction

    assign ea_s        = operand_a_i + operand_imm_i;
    assign addr_word_s = {ea_s[31:2], 2'b00};
    assign mem_op_s    = load_flag_i | store_flag_i;
    assign start_s     = (state_r == S_IDLE) & mem_op_s & ~misaligned_s;

    // Alignment check on the effective address for the requested access size.
    always_comb begin
        misaligned_s = 1'b0;
        case (LSU_type_i)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = ea_s[0];
            default: misaligned_s = |ea_s[1:0];
        endcase
    end

    // Next-state logic of the request / wait sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_nxt_s = S_REQ;
                else         state_nxt_s = S_IDLE;
            end
            S_REQ: begin
                if (mem_gnt_i) state_nxt_s = S_WAIT;
                else           state_nxt_s = S_REQ;
            end
            S_WAIT: begin
                if (mem_rvalid_i) state_nxt_s = S_IDLE;
                else              state_nxt_s = S_WAIT;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Stall request. It drops in the cycle the response arrives so that the
    // upstream stage can advance at the same edge the result is captured.
    always_comb begin
        lsu_hold_flag_o = 1'b0;
        case (state_r)
            S_IDLE:  lsu_hold_flag_o = start_s;
            S_REQ:   lsu_hold_flag_o = 1'b1;
            S_WAIT:  lsu_hold_flag_o = ~mem_rvalid_i;
            default: lsu_hold_flag_o = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Latch the request fields when an access starts; hold them until the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= 32'h0000_0000;
            mem_wstrb_r   <= 4'b0000;
            off_r         <= 2'b00;
            size_r        <= 2'b00;
            signed_r      <= 1'b0;
            wb_addr_lat_r <= 5'd0;
            wb_flag_lat_r <= 1'b0;
        end else if (start_s) begin
            mem_req_r     <= 1'b1;
            mem_we_r      <= store_flag_i;
            mem_addr_r    <= addr_word_s[ADDR_W-1:0];
            mem_wdata_r   <= store_flag_i ? fmt_wdata(LSU_type_i, operand_b_i) : 32'h0000_0000;
            mem_wstrb_r   <= store_flag_i ? fmt_wstrb(LSU_type_i, ea_s[1:0]) : 4'b0000;
            off_r         <= ea_s[1:0];
            size_r        <= LSU_type_i;
            signed_r      <= LSU_signed_i;
            wb_addr_lat_r <= wb_addr_i;
            wb_flag_lat_r <= wb_flag_i;
        end else if ((state_r == S_REQ) && mem_gnt_i) begin
            mem_req_r     <= 1'b0;
        end else begin
            mem_req_r     <= mem_req_r & (state_r == S_REQ);
        end
    end

    // Write-back bundle. During a stall it is a bubble (flag 0). The memory
    // result is committed once, at the response edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_flag_r    <= 1'b0;
            wb_addr_r    <= 5'd0;
            wb_data_r    <= 32'h0000_0000;
            misaligned_r <= 1'b0;
        end else begin
            misaligned_r <= (state_r == S_IDLE) & mem_op_s & misaligned_s;
            case (state_r)
                S_IDLE: begin
                    if (!mem_op_s || misaligned_s) begin
                        wb_flag_r <= wb_flag_i & ~mem_op_s;
                        wb_addr_r <= wb_addr_i;
                        wb_data_r <= wb_data_ex_i;
                    end else begin
                        wb_flag_r <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        wb_flag_r <= wb_flag_lat_r;
                        wb_addr_r <= wb_addr_lat_r;
                        wb_data_r <= mem_we_r ? 32'h0000_0000
                                              : fmt_rdata(size_r, off_r, signed_r, mem_rdata_i);
                    end else begin
                        wb_flag_r <= 1'b0;
                    end
                end
                default: wb_flag_r <= 1'b0;
            endcase
        end
    end

    assign mem_req_o    = mem_req_r;
    assign mem_we_o     = mem_we_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_wdata_o  = mem_wdata_r;
    assign mem_wstrb_o  = mem_wstrb_r;
    assign misaligned_o = misaligned_r;
    assign wb_flag_o    = wb_flag_r;
    assign wb_addr_o    = wb_addr_r;
    assign wb_data_o    = wb_data_r;

endmodule

// File: tb/tb_ysyx_23060072_lsu_stage.sv
// Self-checking bench for ysyx_23060072_lsu_stage: directed scenarios followed
// by random loads, stores and ALU ops. The expected values come from a
// lane/arithmetic reference model.
module tb_ysyx_23060072_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_flag_i, store_flag_i, load_flag_i, LSU_signed_i;
    logic [1:0]  LSU_type_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] operand_a_i, operand_b_i, operand_imm_i, wb_data_ex_i;
    logic        lsu_hold_flag_o, misaligned_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_flag_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_23060072_lsu_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_flag_i(wb_flag_i), .LSU_type_i(LSU_type_i), .store_flag_i(store_flag_i),
        .load_flag_i(load_flag_i), .LSU_signed_i(LSU_signed_i), .wb_addr_i(wb_addr_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_imm_i(operand_imm_i),
        .wb_data_ex_i(wb_data_ex_i), .lsu_hold_flag_o(lsu_hold_flag_o),
        .misaligned_o(misaligned_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_flag_o(wb_flag_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nop_inputs();
        wb_flag_i = 1'b0; LSU_type_i = 2'b00; store_flag_i = 1'b0; load_flag_i = 1'b0;
        LSU_signed_i = 1'b0; wb_addr_i = 5'd0; operand_a_i = 32'd0; operand_b_i = 32'd0;
        operand_imm_i = 32'd0; wb_data_ex_i = 32'd0;
    endtask

    // Reference: value a load returns, from lane arithmetic on the read word.
    function automatic logic [31:0] ref_load(input logic [1:0] ty, input bit sg,
                                             input int off, input logic [31:0] rd);
        logic [31:0] v;
        if (ty == 2'd0) begin
            v = (rd >> (8 * off)) & 32'h0000_00FF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (ty == 2'd1) begin
            v = (rd >> (8 * (off & 2))) & 32'h0000_FFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One instruction through the stage with a scripted memory response.
    task automatic do_op(input bit ld, input bit st, input logic [1:0] ty, input bit sg,
                         input bit wf, input logic [4:0] wa, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] wd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        logic [31:0] ea, exp_wdata;
        logic [3:0]  exp_strb;
        int off, holds;
        bit mem, mis;
        ea  = a + imm;
        off = int'(ea % 32'd4);
        mem = ld || st;
        mis = mem && ((ty == 2'd1 && (off % 2) == 1) || (ty >= 2'd2 && off != 0));
        if (ty == 2'd0)      begin exp_strb = 4'(1 << off);       exp_wdata = {24'd0, b[7:0]} * 32'h0101_0101; end
        else if (ty == 2'd1) begin exp_strb = 4'(3 << (off & 2)); exp_wdata = {16'd0, b[15:0]} * 32'h0001_0001; end
        else                 begin exp_strb = 4'hF;               exp_wdata = b; end
        if (!st) exp_strb = 4'h0;

        @(negedge clk);
        wb_flag_i = wf; LSU_type_i = ty; store_flag_i = st; load_flag_i = ld;
        LSU_signed_i = sg; wb_addr_i = wa; operand_a_i = a; operand_b_i = b;
        operand_imm_i = imm; wb_data_ex_i = wd;
        #1;
        if (!mem || mis) begin
            chk("hold_nomem", lsu_hold_flag_o, 32'd0);
            @(posedge clk); #1;
            nop_inputs();
            chk("misaligned_pulse", misaligned_o, mis);
            chk("req_nomem", mem_req_o, 32'd0);
            chk("wb_flag_nomem", wb_flag_o, (wf && !mis));
            if (!mis) begin
                chk("wb_addr_alu", wb_addr_o, wa);
                chk("wb_data_alu", wb_data_o, wd);
            end
        end else begin
            holds = 0;
            chk("hold_idle", lsu_hold_flag_o, 32'd1);
            if (lsu_hold_flag_o) holds++;
            @(posedge clk); #1;
            chk("misaligned_mem", misaligned_o, 32'd0);
            for (int i = 0; i <= gnt_dly; i++) begin
                chk("req_high", mem_req_o, 32'd1);
                chk("req_we", mem_we_o, st);
                chk("req_addr", mem_addr_o, ea & 32'hFFFF_FFFC);
                chk("req_wstrb", mem_wstrb_o, exp_strb);
                if (st) chk("req_wdata", mem_wdata_o, exp_wdata);
                chk("bubble_req", wb_flag_o, 32'd0);
                chk("hold_req", lsu_hold_flag_o, 32'd1);
                if (lsu_hold_flag_o) holds++;
                mem_gnt_i = (i == gnt_dly);
                @(posedge clk); #1;
                mem_gnt_i = 1'b0;
            end
            for (int i = 0; i <= rv_dly; i++) begin
                chk("req_low_wait", mem_req_o, 32'd0);
                mem_rvalid_i = (i == rv_dly);
                mem_rdata_i  = (i == rv_dly) ? rdata : $urandom;
                #1;
                chk("hold_wait", lsu_hold_flag_o, (i != rv_dly));
                if (lsu_hold_flag_o) holds++;
                @(posedge clk); #1;
                mem_rvalid_i = 1'b0;
                if (i != rv_dly) chk("bubble_wait", wb_flag_o, 32'd0);
            end
            nop_inputs();
            chk("wb_flag_mem", wb_flag_o, wf);
            chk("wb_addr_mem", wb_addr_o, wa);
            chk("wb_data_mem", wb_data_o, st ? 32'd0 : ref_load(ty, sg, off, rdata));
            chk("hold_cycles", holds, gnt_dly + rv_dly + 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ld, st;
        rst_n = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        nop_inputs();
        #12;
        chk("rst_req", mem_req_o, 32'd0);
        chk("rst_we", mem_we_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_wstrb", mem_wstrb_o, 32'd0);
        chk("rst_wb_flag", wb_flag_o, 32'd0);
        chk("rst_wb_addr", wb_addr_o, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_misaligned", misaligned_o, 32'd0);
        chk("rst_hold", lsu_hold_flag_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ALU pass-through
        do_op(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5, 32'd0, 32'd0, 32'd0, 32'h1234, 0, 0, 32'd0);
        // signed byte load, lane 3
        do_op(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd6, 32'h1000, 32'd0, 32'd3, 32'd0, 0, 0, 32'h80AA_BBCC);
        // halfword store with delayed grant
        do_op(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 32'h2000, 32'hDEAD_BEEF, 32'd2, 32'd0, 2, 0, 32'd0);
        // misaligned word load, then an ALU op to see the pulse end
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd7, 32'h3000, 32'd0, 32'd2, 32'h55, 0, 0, 32'd0);
        do_op(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd8, 32'd0, 32'd0, 32'd0, 32'h77, 0, 0, 32'd0);
        // unsigned half load at lane 2, back-to-back with another load
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd9, 32'h4000, 32'd0, 32'd2, 32'd0, 0, 1, 32'h8001_0000);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10, 32'h4000, 32'd0, 32'd4, 32'd0, 1, 2, 32'h1357_9BDF);

        // reset while waiting for the response
        @(negedge clk);
        load_flag_i = 1'b1; LSU_type_i = 2'd2; wb_flag_i = 1'b1; wb_addr_i = 5'd11;
        operand_a_i = 32'h5000;
        @(posedge clk); #1; mem_gnt_i = 1'b1;
        @(posedge clk); #1; mem_gnt_i = 1'b0;
        chk("rstw_hold_before", lsu_hold_flag_o, 32'd1);
        #2; rst_n = 1'b0; nop_inputs();
        #1;
        chk("rstw_req", mem_req_o, 32'd0);
        chk("rstw_hold", lsu_hold_flag_o, 32'd0);
        chk("rstw_addr", mem_addr_o, 32'd0);
        chk("rstw_wb_flag", wb_flag_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        wb_flag_i = 1'b1; wb_addr_i = 5'd12; wb_data_ex_i = 32'hCAFE;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1; mem_rvalid_i = 1'b0;
        chk("late_rvalid_flag", wb_flag_o, 32'd1);
        chk("late_rvalid_addr", wb_addr_o, 32'd12);
        chk("late_rvalid_data", wb_data_o, 32'hCAFE);
        chk("late_rvalid_hold", lsu_hold_flag_o, 32'd0);
        nop_inputs();

        // random mix
        for (int n = 0; n < 80; n++) begin
            logic [1:0] ty;
            logic [31:0] a, imm;
            int kind;
            kind = $urandom_range(0, 3);
            ld = (kind == 1) || (kind == 2);
            st = (kind == 3);
            ty = 2'($urandom_range(0, 3));
            a   = $urandom & 32'hFFFF_FFFC;
            imm = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : ($urandom & 32'hFFFF_FFFE);
            do_op(ld, st, ty, 1'($urandom), st ? 1'b0 : 1'($urandom), 5'($urandom), a, $urandom,
                  imm, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060072_lsu_stage.md
Name: ysyx_23060072_lsu_stage

Overview:
- Receiving end of the ex_stage→lsu_stage pipeline register interface.
- Takes the registered control and data bundle from ex_stage and computes the effective address operand_a+operand_imm.
- For loads and stores, runs an SRAM-style req/gnt/rvalid transaction, formats store and load data, and stalls the pipeline through the controller.
- Produces the registered write-back bundle for wb_stage.

Parameters:
- ADDR_W, 32, width of mem_addr_o; the effective address is truncated to ADDR_W bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_flag_i  in  1  instruction writes the register file.
- LSU_type_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- store_flag_i  in  1  store instruction.
- load_flag_i  in  1  load instruction.
- LSU_signed_i  in  1  1 = sign-extend load data, 0 = zero-extend.
- wb_addr_i  in  5  destination register.
- operand_a_i  in  32  base (rs1 value).
- operand_b_i  in  32  store data (rs2 value).
- operand_imm_i  in  32  offset.
- wb_data_ex_i  in  32  ALU/CSR result.
- lsu_hold_flag_o  out  1  stall request to the controller (combinational).
- misaligned_o  out  1  one-cycle pulse on a misaligned access.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word-aligned address.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_wstrb_o  out  4  byte enables (0000 on reads).
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response valid: read data, or write acknowledge.
- mem_rdata_i  in  32  read data.
- wb_flag_o  out  1  registered to wb_stage.
- wb_addr_o  out  5  registered to wb_stage.
- wb_data_o  out  32  registered to wb_stage.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transaction):
  - FSM goes to IDLE.
  - All outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, wb_flag_o, wb_addr_o, wb_data_o, misaligned_o.
  - All latched request registers are 0.
- Definitions:
  - mem_op = load_flag_i | store_flag_i.
  - ea = operand_a_i + operand_imm_i, modulo 2^32.
- Misalignment:
  - A half access is misaligned when ea[0]=1.
  - A word access is misaligned when ea[1:0]≠0.
  - On a misaligned access: no memory request is issued, misaligned_o pulses for 1 cycle, the op is treated as non-memory, and wb_flag_o is forced to 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE with no mem_op: input bundle registers to the wb outputs at the next edge (1-cycle latency). wb_data_o = wb_data_ex_i. Hold is 0.
  - IDLE with an aligned mem_op:
    - Latch the request: addr = {ea[31:2],2'b00}, we = store_flag_i, byte offset ea[1:0], LSU_type, signed, wb_addr, wb_flag.
    - Go to REQ. Hold is 1.
  - REQ: mem_req_o=1 with the latched fields, held stable until mem_gnt_i=1. On gnt, go to WAIT. Hold is 1.
  - WAIT: mem_req_o=0. Hold = !mem_rvalid_i. On rvalid, go to IDLE and capture the result into the wb outputs at the same edge.
  - Memory protocol: rvalid never arrives in the same cycle as its gnt. At most one transaction is outstanding.
- lsu_hold_flag_o = (IDLE & mem_op & aligned) | REQ | (WAIT & !mem_rvalid_i).
  - While hold is asserted, the upstream inputs are stable.
  - While hold is asserted, wb_flag_o is registered as 0 (bubble), so wb_stage never sees a duplicate retire.
- Store formatting:
  - byte: wstrb = 0001<<off, wdata = {4{b[7:0]}}.
  - half: wstrb = 0011<<{off[1],0}, wdata = {2{b[15:0]}}.
  - word: wstrb = 1111, wdata = b.
  - On the store rvalid, wb_flag_o = latched wb_flag (0 for stores) and wb_data_o = 0.
- Load formatting: select the byte at lane off, or the half at lane off[1], then sign- or zero-extend per latched signed. Word loads pass the data straight through. wb_flag_o = latched wb_flag.
- Minimum latency for an aligned load or store is 3 cycles: IDLE, REQ with gnt, WAIT with rvalid. Each extra gnt or rvalid wait cycle adds one cycle.
- mem_rvalid_i or mem_gnt_i arriving in IDLE is ignored.

Test Plan:
- ALU pass-through: wb_flag_i=1, wb_addr_i=5, wb_data_ex_i=0x1234, no mem_op → next cycle wb_flag_o=1, wb_addr_o=5, wb_data_o=0x1234, hold never asserted.
- Signed byte load:
  - Stimulus: a=0x1000, imm=3, LSU_type=00, signed=1, gnt immediate, rvalid one cycle later with rdata=0x80AABBCC.
  - Response: mem_addr_o=0x1000, hold high for exactly 2 cycles, wb_data_o=0xFFFFFF80.
- Halfword store with delayed gnt:
  - Stimulus: a=0x2000, imm=2, b=0xDEADBEEF, gnt after 3 cycles.
  - Response: mem_req_o stays high with stable fields for 3 cycles; mem_wstrb_o=1100, mem_wdata_o=0xBEEFBEEF, mem_we_o=1; wb_flag_o=0.
- Misaligned word load at ea=0x3002 → misaligned_o pulses 1 cycle, mem_req_o stays 0, wb_flag_o=0, no hold.
- Unsigned half load at off=2 with rdata=0x8001_0000 → wb_data_o=0x00008001; back-to-back with a second load, no duplicate wb_flag_o pulse.
- Reset asserted in WAIT → mem_req_o and hold drop immediately, FSM in IDLE, and a subsequent late rvalid is ignored.
